// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared definitions for the buzzer player.
//   state_e   : playback FSM states
//   DUR_*     : duration field (beats) position in a ROM word
//   TONE_*    : half-period code field position in a ROM word
//   END_MARK  : duration value marking end of track
package buzzer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2,
    ST_PLAY  = 2'd3
  } state_e;

  localparam int DUR_MSB  = 11;
  localparam int DUR_LSB  = 8;
  localparam int TONE_MSB = 7;
  localparam int TONE_LSB = 0;

  localparam logic [DUR_MSB-DUR_LSB:0] END_MARK = '0;

endpackage

// File: rtl/buzzer_tone_gen.sv
// buzzer_tone_gen: square-wave divider for one note.
//   clk    : clock
//   rst    : synchronous active-high reset
//   enable : high while a note is sounding; low clears the divider
//   code   : half-period code, half period = code * PRESCALE cycles (0 = rest)
//   wave   : square wave, starts low when enable rises, forced low when disabled
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int PRESCALE = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] code,
  output logic       wave
);

  localparam int HP_W = $clog2(255 * PRESCALE + 1);

  logic [HP_W-1:0] cnt_q;
  logic [HP_W-1:0] half;
  logic            wave_q;

  assign half = HP_W'(code) * HP_W'(PRESCALE);

  always_ff @(posedge clk) begin
    if (rst || !enable || (code == 8'd0)) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (cnt_q == half - HP_W'(1)) begin
      cnt_q  <= '0;
      wave_q <= ~wave_q;
    end else begin
      cnt_q  <= cnt_q + HP_W'(1);
    end
  end

  // Gate so the piezo goes quiet the same cycle the note ends.
  assign wave = wave_q & enable;

endmodule

// File: rtl/buzzer_player.sv
// buzzer_player: plays a note list from a synchronous ROM onto a piezo.
//   clk         : clock, all logic on posedge
//   rst         : synchronous active-high reset
//   start       : pulse, begin playback at address 0 (ignored while busy)
//   stop        : pulse, abort playback (wins over start)
//   rom_en      : ROM read enable (FETCH only)
//   rom_addr    : ROM read address
//   rom_data    : ROM word, valid the cycle after rom_en
//   buzzer      : square-wave drive
//   busy        : high whenever not IDLE
//   note_strobe : one-cycle pulse when a note starts
// Word: [11:8] beats (0 = end of track), [7:0] half-period code (0 = rest).
// Config macro BUZZER_PLAYER_LOOP_EN: end of track restarts at address 0
// instead of returning to IDLE.
module buzzer_player
  import buzzer_pkg::*;
#(
  parameter int ADDR_WIDTH    = 16,
  parameter int DATA_WIDTH    = 12,
  parameter int BEAT_CYCLES   = 12_500_000,
  parameter int TONE_PRESCALE = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  buzzer,
  output logic                  busy,
  output logic                  note_strobe
);

  localparam int TIMER_W = $clog2(15 * BEAT_CYCLES + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [7:0]            tone_q, tone_d;

  logic [DUR_MSB-DUR_LSB:0]   dur;
  logic [TONE_MSB-TONE_LSB:0] code;

  assign dur  = rom_data[DUR_MSB:DUR_LSB];
  assign code = rom_data[TONE_MSB:TONE_LSB];

  if (DATA_WIDTH > 12) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^rom_data[DATA_WIDTH-1:12];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    timer_d = timer_q;
    tone_d  = tone_q;
    if (stop) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_FETCH;
            addr_d  = '0;
          end
        end
        ST_FETCH: state_d = ST_LATCH;
        ST_LATCH: begin
          if (dur == END_MARK) begin
`ifdef BUZZER_PLAYER_LOOP_EN
            addr_d  = '0;
            state_d = ST_FETCH;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            state_d = ST_PLAY;
            tone_d  = code;
            timer_d = TIMER_W'(dur) * TIMER_W'(BEAT_CYCLES);
          end
        end
        ST_PLAY: begin
          // Loaded with beats*BEAT_CYCLES; ending at 1 gives exactly that
          // many PLAY cycles.
          if (timer_q <= TIMER_W'(1)) begin
            timer_d = '0;
            addr_d  = addr_q + ADDR_WIDTH'(1);
            state_d = ST_FETCH;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      timer_q <= '0;
      tone_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      timer_q <= timer_d;
      tone_q  <= tone_d;
    end
  end

  buzzer_tone_gen #(
    .PRESCALE (TONE_PRESCALE)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .enable (state_q == ST_PLAY),
    .code   (tone_q),
    .wave   (buzzer)
  );

  assign rom_en      = (state_q == ST_FETCH);
  assign rom_addr    = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign note_strobe = (state_q == ST_LATCH) && (dur != END_MARK);

endmodule
